// File: rtl/sram_io_host_pkg.sv
// Shared constants and state encodings for the serial SRAM I/O host.
// CTRL codes are the responder's mode encoding on the CTRL pins.
package sram_io_host_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 9;
  localparam int N_STROBES = ADDR_W + DATA_W + 1;

  localparam logic [1:0] CTRL_SHIFT = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b11;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_LOW,
    PH_RELEASE
  } strobe_ph_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_RUN,
    HS_DONE
  } host_st_e;

endpackage

// File: rtl/sram_io_bit_strobe.sv
// One SETUP/LOW/RELEASE strobe handshake towards the SRAM I/O controller.
// Optional RDY abort counter enabled by SRAM_IO_HOST_TIMEOUT_EN.
module sram_io_bit_strobe
  import sram_io_host_pkg::*;
#(
  parameter int LOW_MIN     = 3,
  parameter int RDY_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       si_i,
  input  logic [1:0] ctrl_i,
  input  logic       rdy_i,
  output logic       done_o,
  output logic       err_o,
  output logic       load_n_o,
  output logic       si_o,
  output logic [1:0] ctrl_o
);

  localparam int CNT_W = $clog2(RDY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOW_MIN_C = CNT_W'(LOW_MIN);

  strobe_ph_e       ph_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_n_q;
  logic             si_q;
  logic             err_q;
  logic [1:0]       ctrl_q;
  logic             timeout;

`ifdef SRAM_IO_HOST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(RDY_TIMEOUT);
  assign timeout = (cnt_q >= TIMEOUT_C);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= PH_IDLE;
      cnt_q    <= '0;
      load_n_q <= 1'b1;
      si_q     <= 1'b0;
      err_q    <= 1'b0;
      ctrl_q   <= CTRL_SHIFT;
    end else begin
      case (ph_q)
        PH_IDLE, PH_RELEASE: begin
          if (start_i) begin
            ph_q   <= PH_SETUP;
            si_q   <= si_i;
            ctrl_q <= ctrl_i;
            err_q  <= 1'b0;
          end else begin
            ph_q   <= PH_IDLE;
            si_q   <= 1'b0;
            ctrl_q <= CTRL_SHIFT;
          end
        end
        PH_SETUP: begin
          ph_q     <= PH_LOW;
          load_n_q <= 1'b0;
          cnt_q    <= CNT_W'(1);
        end
        PH_LOW: begin
          if (cnt_q >= LOW_MIN_C && rdy_i) begin
            ph_q     <= PH_RELEASE;
            load_n_q <= 1'b1;
          end else if (timeout) begin
            // Abort parks the bus in SHIFT mode so the responder sees nothing further.
            ph_q     <= PH_RELEASE;
            load_n_q <= 1'b1;
            si_q     <= 1'b0;
            ctrl_q   <= CTRL_SHIFT;
            err_q    <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ph_q <= PH_IDLE;
      endcase
    end
  end

  assign done_o   = (ph_q == PH_RELEASE);
  assign err_o    = err_q;
  assign load_n_o = load_n_q;
  assign si_o     = si_q;
  assign ctrl_o   = ctrl_q;

endmodule

// File: rtl/sram_io_host.sv
// Serial SRAM I/O host: turns one parallel read/write into 18 controller strobes.
// Build with SRAM_IO_HOST_TIMEOUT_EN to abort strobes whose RDY never arrives.
module sram_io_host
  import sram_io_host_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = DATA_W,
  parameter int MEMORY_ADDR_WIDTH = ADDR_W,
  parameter int LOW_MIN           = 3,
  parameter int RDY_TIMEOUT       = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [MEMORY_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [MEMORY_DATA_WIDTH-1:0] req_wdata_i,
  output logic                         rsp_valid_o,
  output logic [MEMORY_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         bgn_o,
  output logic                         si_o,
  output logic                         load_n_o,
  output logic [1:0]                   ctrl_o,
  input  logic                         rdy_i,
  input  logic                         so_i
);

  localparam int TX_W  = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int N_STR = TX_W + 1;
  localparam int IDX_W = $clog2(N_STR + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STR);
  localparam logic [IDX_W-1:0] WRITE_IDX = IDX_W'(TX_W);
  localparam logic [IDX_W-1:0] READ_IDX  = IDX_W'(MEMORY_ADDR_WIDTH);

  host_st_e                     st_q;
  logic                         ready_q, rsp_valid_q, rsp_err_q, bgn_q;
  logic [MEMORY_DATA_WIDTH-1:0] rdata_q;
  logic                         we_q, cap_q;
  logic [TX_W-1:0]              tx_q;
  logic [IDX_W-1:0]             idx_q;
  logic [MEMORY_DATA_WIDTH-1:0] rx_q;

  logic             accept, start, we_d, si_d;
  logic [TX_W-1:0]  tx_d;
  logic [IDX_W-1:0] idx_d;
  logic [1:0]       ctrl_d;
  logic             strb_done, strb_err;

  assign accept = (st_q == HS_IDLE) && ready_q && req_valid_i;

  // The first strobe is launched on the accept edge, so its bit comes straight from the request.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_d  = tx_q;
    idx_d = idx_q;
    we_d  = we_q;
    if (accept) begin
      we_d  = req_we_i;
      idx_d = '0;
      tx_d  = req_we_i ? {req_addr_i, req_wdata_i}
                       : {{MEMORY_DATA_WIDTH{1'b0}}, req_addr_i};
    end
    start = accept ||
            ((st_q == HS_RUN) && strb_done && !strb_err && (idx_q != LAST_IDX));
    si_d  = tx_d[0];
    if (we_d) ctrl_d = (idx_d == WRITE_IDX) ? CTRL_WRITE : CTRL_SHIFT;
    else      ctrl_d = (idx_d == READ_IDX)  ? CTRL_READ  : CTRL_SHIFT;
  end

  // NOTE: the request/shift datapath is not reset; it is always reloaded on accept before use.
  always_ff @(posedge clk_i) begin
    cap_q <= 1'b0;
    if (start) begin
      tx_q  <= tx_d >> 1;
      idx_q <= idx_d + 1'b1;
      we_q  <= we_d;
      cap_q <= !we_d && (idx_d > READ_IDX);
    end
    if (cap_q) rx_q <= {so_i, rx_q[MEMORY_DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q        <= HS_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      bgn_q       <= 1'b0;
    end else begin
      bgn_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (st_q)
        HS_IDLE: begin
          if (accept) begin
            st_q    <= HS_RUN;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        HS_RUN: begin
          if (strb_done && (strb_err || idx_q == LAST_IDX)) begin
            st_q        <= HS_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= strb_err;
            rdata_q     <= (we_q || strb_err) ? '0 : rx_q;
          end
        end
        HS_DONE: begin
          st_q    <= HS_IDLE;
          ready_q <= 1'b1;
        end
        default: st_q <= HS_IDLE;
      endcase
    end
  end

  sram_io_bit_strobe #(
    .LOW_MIN     (LOW_MIN),
    .RDY_TIMEOUT (RDY_TIMEOUT)
  ) u_strobe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .si_i     (si_d),
    .ctrl_i   (ctrl_d),
    .rdy_i    (rdy_i),
    .done_o   (strb_done),
    .err_o    (strb_err),
    .load_n_o (load_n_o),
    .si_o     (si_o),
    .ctrl_o   (ctrl_o)
  );

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign bgn_o       = bgn_q;

endmodule

// File: tb/tb_sram_io_host.sv
// Directed bench for sram_io_host with a behavioural SRAM_IO_CTRL responder.
// Define SRAM_IO_HOST_TIMEOUT_EN to also exercise the RDY abort path.
module tb_sram_io_host;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_we_i = 1'b0;
  logic [8:0] req_addr_i = '0;
  logic [7:0] req_wdata_i = '0;
  logic       req_ready_o, rsp_valid_o, rsp_err_o, bgn_o, si_o, load_n_o;
  logic [7:0] rsp_rdata_o;
  logic [1:0] ctrl_o;
  logic       rdy_i = 1'b1;
  logic       so_i = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  sram_io_host #(
    .MEMORY_DATA_WIDTH (8),
    .MEMORY_ADDR_WIDTH (9),
    .LOW_MIN           (3),
    .RDY_TIMEOUT       (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .bgn_o       (bgn_o),
    .si_o        (si_o),
    .load_n_o    (load_n_o),
    .ctrl_o      (ctrl_o),
    .rdy_i       (rdy_i),
    .so_i        (so_i)
  );

  always #5 clk = ~clk;

  // Responder model: acts on each LOAD_N falling edge, drives RDY after rdy_from LOW cycles.
  logic [7:0]  mem [0:511] = '{default: 8'h00};
  logic [16:0] sr = '0;
  logic [7:0]  out_sr = '0;
  logic        prev_load_n = 1'b1;
  logic [1:0]  ctrl_log[$];
  logic        si_log[$];
  int          nstrb = 0;
  int          lowcnt = 0;
  int          last_low = 0;
  int          rdy_from = 0;
  bit          rdy_stuck = 1'b0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (!load_n_o) begin
      if (prev_load_n) begin
        ctrl_log.push_back(ctrl_o);
        si_log.push_back(si_o);
        nstrb <= nstrb + 1;
        case (ctrl_o)
          2'b00: begin
            sr     <= {si_o, sr[16:1]};
            out_sr <= out_sr >> 1;
            so_i   <= out_sr[1];
          end
          2'b01: begin
            out_sr <= mem[sr[16:8]];
            so_i   <= mem[sr[16:8]][0];
          end
          2'b11:   mem[sr[16:8]] <= sr[7:0];
          default: ;
        endcase
      end
      lowcnt <= lowcnt + 1;
      rdy_i  <= !rdy_stuck && (lowcnt + 1 >= rdy_from);
    end else begin
      if (!prev_load_n) last_low <= lowcnt;
      lowcnt <= 0;
      rdy_i  <= !rdy_stuck && (rdy_from <= 0);
    end
    prev_load_n <= load_n_o;
  end

  always @(posedge clk) begin
    if (!rst_i && req_valid_i && req_ready_o) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and returns the cycle (counted from the accept edge) of RSP_VALID.
  task automatic do_req(input logic we, input logic [8:0] addr, input logic [7:0] wdata,
                        input bit hold, output int cyc, output logic [7:0] rdata,
                        output logic err, output int base);
    int w;
    @(negedge clk);
    #1;
    base        = nstrb;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    w = 0;
    while (!req_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_accept", 32'(req_ready_o), 1);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_we_i    = 1'b1;
      req_addr_i  = addr + 9'd1;
      req_wdata_i = 8'hFF;
    end else begin
      req_valid_i = 1'b0;
    end
    cyc = 1;
    while (!rsp_valid_o && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    req_valid_i = 1'b0;
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
  endtask

  function automatic logic [31:0] si_vec(int base, int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = si_log[base + i];
    return v;
  endfunction

  function automatic int count_ctrl(int base, logic [1:0] c);
    int k = 0;
    for (int i = 0; i < 18; i++) if (ctrl_log[base + i] == c) k++;
    return k;
  endfunction

  task automatic check_tail();
    @(negedge clk);
    check("rsp_valid_one_cycle", 32'(rsp_valid_o), 0);
    check("ready_after_done", 32'(req_ready_o), 1);
  endtask

  initial begin
    int cyc, base, w, v, a0;
    logic [7:0] rd;
    logic err;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready_o), 0);
    check("rst_bgn", 32'(bgn_o), 0);
    check("rst_load_n", 32'(load_n_o), 1);
    check("rst_ctrl", 32'(ctrl_o), 0);
    check("rst_misc_zero", {20'd0, rsp_valid_o, rsp_err_o, si_o, 1'b0, rsp_rdata_o}, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("bgn_after_rst", 32'(bgn_o), 1);
    check("ready_after_rst", 32'(req_ready_o), 1);

    // Write 0x020 <- 0x34 with RDY immediate.
    do_req(1'b1, 9'h020, 8'h34, 1'b0, cyc, rd, err, base);
    check("wr_rsp_cycle", cyc, 91);
    check("wr_err", 32'(err), 0);
    check("wr_rdata", 32'(rd), 0);
    check("wr_strobes", nstrb - base, 18);
    check("wr_si_seq", si_vec(base, 17), 'h02034);
    check("wr_shift_cnt", count_ctrl(base, 2'b00), 17);
    check("wr_last_ctrl", 32'(ctrl_log[base + 17]), 3);
    check("wr_mem", 32'(mem[9'h020]), 'h34);
    check("wr_low_len", last_low, 3);
    check_tail();

    // Read it back.
    do_req(1'b0, 9'h020, 8'h00, 1'b0, cyc, rd, err, base);
    check("rd_rsp_cycle", cyc, 91);
    check("rd_rdata", 32'(rd), 'h34);
    check("rd_err", 32'(err), 0);
    check("rd_si_seq", si_vec(base, 18), 'h020);
    check("rd_read_pos", 32'(ctrl_log[base + 9]), 1);
    check("rd_shift_cnt", count_ctrl(base, 2'b00), 17);
    check_tail();

    // RDY delayed two extra cycles on every strobe.
    rdy_from = 5;
    do_req(1'b1, 9'h1A3, 8'h5C, 1'b0, cyc, rd, err, base);
    check("dly_wr_cycle", cyc, 127);
    check("dly_low_len", last_low, 5);
    check("dly_mem", 32'(mem[9'h1A3]), 'h5C);
    do_req(1'b0, 9'h1A3, 8'h00, 1'b0, cyc, rd, err, base);
    check("dly_rd_cycle", cyc, 127);
    check("dly_rd_rdata", 32'(rd), 'h5C);
    rdy_from = 0;
    check_tail();

    // Reset during the 8th SHIFT strobe of a write.
    @(negedge clk);
    #1;
    base        = nstrb;
    req_we_i    = 1'b1;
    req_addr_i  = 9'h055;
    req_wdata_i = 8'h66;
    req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    w = 0;
    while ((nstrb - base) < 8 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("mid_rst_reached_8", nstrb - base, 8);
    check("mid_rst_load_low", 32'(load_n_o), 0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_load_n", 32'(load_n_o), 1);
    check("mid_rst_ctrl", 32'(ctrl_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    v = 0;
    repeat (120) begin
      @(negedge clk);
      if (rsp_valid_o) v++;
    end
    check("mid_rst_no_rsp", v, 0);
    check("mid_rst_no_write", 32'(mem[9'h055]), 0);

    do_req(1'b1, 9'h1FF, 8'hA5, 1'b0, cyc, rd, err, base);
    check("post_rst_wr_cycle", cyc, 91);
    check("post_rst_mem", 32'(mem[9'h1FF]), 'hA5);
    do_req(1'b0, 9'h1FF, 8'h00, 1'b0, cyc, rd, err, base);
    check("post_rst_rdata", 32'(rd), 'hA5);
    check_tail();

    // REQ_VALID held with fields changing after accept.
    a0 = acc_cnt;
    do_req(1'b1, 9'h0F0, 8'h3C, 1'b1, cyc, rd, err, base);
    check("hold_rsp_cycle", cyc, 91);
    repeat (2) @(negedge clk);
    check("hold_one_accept", acc_cnt - a0, 1);
    check("hold_mem_orig", 32'(mem[9'h0F0]), 'h3C);
    check("hold_mem_other", 32'(mem[9'h0F1]), 0);

`ifdef SRAM_IO_HOST_TIMEOUT_EN
    rdy_stuck = 1'b1;
    do_req(1'b1, 9'h0AA, 8'h77, 1'b0, cyc, rd, err, base);
    check("to_rsp_cycle", cyc, 19);
    check("to_err", 32'(err), 1);
    check("to_rdata", 32'(rd), 0);
    check("to_low_len", last_low, 16);
    check("to_one_strobe", nstrb - base, 1);
    check("to_ctrl_parked", 32'(ctrl_o), 0);
    rdy_stuck = 1'b0;
    check_tail();
`else
    check("err_tied_low", 32'(rsp_err_o), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
